master_arbiter: RTL and testbench

- Decides which of two redundant CPUs (A or B) is master and drives the `switch` select used by the core's UART/IO routing.
- Inputs:
  - Heartbeat-health flags from the two PWM pulse detectors.
  - Command-switch and force-switch pulses from the command decoder.
- On a confirmed master failure it swaps master to the healthy standby, then pulses a reset to the failed CPU.
- Reports a both-failed fault and counts switchovers.

---
 rtl/master_arbiter_if.sv | 24 ++
 rtl/master_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_master_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/master_arbiter_if.sv
// Handshake/status bundle between the redundant-CPU master arbiter and the rest of the core.
interface master_arbiter_if;
    logic       io_a;
    logic       io_b;
    logic       com_swi;
    logic       force_swi;
    logic       switch;
    logic       reset_A;
    logic       reset_B;
    logic       busy;
    logic       fault;
    logic       cmd_rej;
    logic [7:0] switch_cnt;

    modport slave (
        input  io_a, io_b, com_swi, force_swi,
        output switch, reset_A, reset_B, busy, fault, cmd_rej, switch_cnt
    );

    modport master (
        output io_a, io_b, com_swi, force_swi,
        input  switch, reset_A, reset_B, busy, fault, cmd_rej, switch_cnt
    );
endinterface

// File: rtl/master_arbiter.sv
// Picks master CPU (A/B), fails over after a health holdoff and pulses reset to the failed CPU.
// Define SWITCH_LOCKOUT_EN to enforce a minimum spacing between switchovers.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ACTIVE    | master healthy, accepting requests
// HOLDOFF   | master health lost, timing out before failover
// SWITCH    | one-cycle swap of the master select
// RESET_OLD | reset pulse to the deselected (failed) CPU
// BOTH_FAIL | master and standby both unhealthy, fault raised
module master_arbiter #(
    parameter int HOLDOFF_CYCLES     = 1000,
    parameter int RESET_PULSE_CYCLES = 100,
    parameter int CNT_W              = 16,
    parameter int LOCKOUT_CYCLES     = 5000
) (
    input  logic              clk,
    input  logic              rst_n,
    master_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        ACTIVE    = 3'd0,
        HOLDOFF   = 3'd1,
        SWITCH    = 3'd2,
        RESET_OLD = 3'd3,
        BOTH_FAIL = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RESET_PULSE_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt;
    logic             fail_flag, fail_nxt;
    logic             switch_q, switch_nxt;
    logic             reset_a_q, reset_a_nxt;
    logic             reset_b_q, reset_b_nxt;
    logic             cmd_rej_q, cmd_rej_nxt;
    logic [7:0]       cnt_q, cnt_nxt;
    logic             master_ok, standby_ok, lock_active;

    assign master_ok  = switch_q ? bus.io_b : bus.io_a;
    assign standby_ok = switch_q ? bus.io_a : bus.io_b;

`ifdef SWITCH_LOCKOUT_EN
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES);
    logic [CNT_W-1:0] lockout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lockout_q <= '0;
        else if (state == SWITCH)
            lockout_q <= LOCK_LOAD;
        else if (lockout_q != '0)
            lockout_q <= lockout_q - 1'b1;
    end

    assign lock_active = (lockout_q != '0);
`else
    // Lockout compiled out: constant-false, no storage.
    assign lock_active = (LOCKOUT_CYCLES < 0);
`endif

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        fail_nxt    = fail_flag;
        switch_nxt  = switch_q;
        reset_a_nxt = reset_a_q;
        reset_b_nxt = reset_b_q;
        cmd_rej_nxt = 1'b0;
        cnt_nxt     = cnt_q;

        case (state)
            ACTIVE: begin
                if (bus.force_swi) begin
                    state_nxt = SWITCH;
                    fail_nxt  = 1'b0;
                end else if (bus.com_swi) begin
                    if (standby_ok && !lock_active) begin
                        state_nxt = SWITCH;
                        fail_nxt  = 1'b0;
                    end else begin
                        cmd_rej_nxt = 1'b1;
                    end
                end else if (!master_ok) begin
                    state_nxt = HOLDOFF;
                    timer_nxt = '0;
                end
            end

            HOLDOFF: begin
                // Timer parks at the last count so a lockout-delayed expiry stays pending.
                timer_nxt = (timer >= HOLD_LAST) ? timer : timer + 1'b1;
                if (bus.force_swi) begin
                    state_nxt = SWITCH;
                    fail_nxt  = 1'b0;
                end else if (bus.com_swi) begin
                    if (standby_ok && !lock_active) begin
                        state_nxt = SWITCH;
                        fail_nxt  = 1'b0;
                    end else begin
                        cmd_rej_nxt = 1'b1;
                    end
                end else if (master_ok) begin
                    state_nxt = ACTIVE;
                end else if ((timer >= HOLD_LAST) && !lock_active) begin
                    if (standby_ok) begin
                        state_nxt = SWITCH;
                        fail_nxt  = 1'b1;
                    end else begin
                        state_nxt = BOTH_FAIL;
                    end
                end
            end

            SWITCH: begin
                switch_nxt = ~switch_q;
                cnt_nxt    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                timer_nxt  = '0;
                if (fail_flag) begin
                    state_nxt = RESET_OLD;
                    // The CPU being deselected is the one that failed.
                    if (switch_q)
                        reset_b_nxt = 1'b1;
                    else
                        reset_a_nxt = 1'b1;
                end else begin
                    state_nxt = ACTIVE;
                end
            end

            RESET_OLD: begin
                if (bus.com_swi)
                    cmd_rej_nxt = 1'b1;
                if (timer == PULSE_LAST) begin
                    state_nxt   = ACTIVE;
                    timer_nxt   = '0;
                    reset_a_nxt = 1'b0;
                    reset_b_nxt = 1'b0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end

            BOTH_FAIL: begin
                if (bus.force_swi) begin
                    state_nxt = SWITCH;
                    fail_nxt  = 1'b0;
                end else if (bus.com_swi) begin
                    cmd_rej_nxt = 1'b1;
                end else if (master_ok) begin
                    state_nxt = ACTIVE;
                end else if (standby_ok) begin
                    state_nxt = SWITCH;
                    fail_nxt  = 1'b0;
                end
            end

            default: state_nxt = ACTIVE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACTIVE;
            timer     <= '0;
            fail_flag <= 1'b0;
            switch_q  <= 1'b0;
            reset_a_q <= 1'b0;
            reset_b_q <= 1'b0;
            cmd_rej_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            fail_flag <= fail_nxt;
            switch_q  <= switch_nxt;
            reset_a_q <= reset_a_nxt;
            reset_b_q <= reset_b_nxt;
            cmd_rej_q <= cmd_rej_nxt;
            cnt_q     <= cnt_nxt;
        end
    end

    assign bus.switch     = switch_q;
    assign bus.reset_A    = reset_a_q;
    assign bus.reset_B    = reset_b_q;
    assign bus.busy       = (state != ACTIVE) | lock_active;
    assign bus.fault      = (state == BOTH_FAIL);
    assign bus.cmd_rej    = cmd_rej_q;
    assign bus.switch_cnt = cnt_q;

endmodule

// File: tb/tb_master_arbiter.sv
// Scoreboard bench for master_arbiter: directed test-plan cases, random traffic, saturation, async reset.
module tb_master_arbiter;

    localparam int H = 8;
    localparam int P = 4;
    localparam int L = 20;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    master_arbiter_if bus();

    master_arbiter #(
        .HOLDOFF_CYCLES(H), .RESET_PULSE_CYCLES(P), .CNT_W(16), .LOCKOUT_CYCLES(L)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct packed {
        logic       sw;
        logic       ra;
        logic       rb;
        logic       busy;
        logic       fault;
        logic       rej;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t pending;
    bit   have_pending;
    int   total = 0;
    int   bad   = 0;

    // Reference model: phase flags and remaining-cycle counters, not a state encoding.
    bit m_sel, m_in_switch, m_sw_fail, m_watch, m_dead, m_rej, m_who;
    int m_cnt, m_rst_left, m_bad, m_lock;

    task automatic model_reset();
        m_sel = 0; m_in_switch = 0; m_sw_fail = 0; m_watch = 0; m_dead = 0;
        m_rej = 0; m_who = 0; m_cnt = 0; m_rst_left = 0; m_bad = 0; m_lock = 0;
    endtask

    task automatic start_switch(input bit failover);
        m_in_switch = 1; m_sw_fail = failover; m_watch = 0; m_dead = 0;
    endtask

    task automatic model_step(input bit f, input bit c, input bit a, input bit b);
        bit mok, sok, was_sw, was_watch, expired;
        int lk;
        mok = m_sel ? b : a;
        sok = m_sel ? a : b;
        lk = m_lock;
        was_sw = m_in_switch;
        was_watch = m_watch;
        expired = m_watch && (m_bad >= H - 1);
        m_rej = 0;
        if (m_in_switch) begin
            m_who = m_sel;
            m_sel = !m_sel;
            if (m_cnt < 255) m_cnt++;
            m_in_switch = 0;
            if (m_sw_fail) m_rst_left = P;
        end else if (m_rst_left > 0) begin
            if (c) m_rej = 1;
            m_rst_left--;
        end else begin
            if (f) start_switch(0);
            else if (c) begin
                if (sok && lk == 0 && !m_dead) start_switch(0);
                else m_rej = 1;
            end else if (m_dead) begin
                if (mok) m_dead = 0;
                else if (sok) start_switch(0);
            end else if (m_watch) begin
                if (mok) m_watch = 0;
                else if (expired && lk == 0) begin
                    if (sok) start_switch(1);
                    else begin m_watch = 0; m_dead = 1; end
                end
            end else if (!mok) begin
                m_watch = 1;
                m_bad = 0;
            end
            if (was_watch && m_watch && m_bad < H - 1) m_bad++;
        end
`ifdef SWITCH_LOCKOUT_EN
        m_lock = was_sw ? L : (lk > 0 ? lk - 1 : 0);
`endif
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.sw    = m_sel;
        e.ra    = (m_rst_left > 0) && (m_who == 0);
        e.rb    = (m_rst_left > 0) && (m_who == 1);
        e.busy  = m_in_switch || (m_rst_left > 0) || m_watch || m_dead || (m_lock > 0);
        e.fault = m_dead;
        e.rej   = m_rej;
        e.cnt   = 8'(m_cnt);
        return e;
    endfunction

    // Inputs driven here are sampled by the next edge; its expected result is queued one cycle later.
    task automatic step(input bit f, input bit c, input bit a, input bit b);
        @(posedge clk);
        #1;
        if (have_pending) sb_q.push_back(pending);
        bus.force_swi = f;
        bus.com_swi   = c;
        bus.io_a      = a;
        bus.io_b      = b;
        model_step(f, c, a, b);
        pending = model_out();
        have_pending = 1;
    endtask

    task automatic flush();
        @(posedge clk);
        #1;
        if (have_pending) sb_q.push_back(pending);
        have_pending = 0;
        bus.force_swi = 0;
        bus.com_swi   = 0;
        @(negedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e, g;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                g = {bus.switch, bus.reset_A, bus.reset_B, bus.busy, bus.fault, bus.cmd_rej, bus.switch_cnt};
                total++;
                if (g !== e) begin
                    bad++;
                    $display("FAIL outputs @%0t: got sw=%0b rA=%0b rB=%0b busy=%0b flt=%0b rej=%0b cnt=%0d, exp sw=%0b rA=%0b rB=%0b busy=%0b flt=%0b rej=%0b cnt=%0d",
                             $time, g.sw, g.ra, g.rb, g.busy, g.fault, g.rej, g.cnt,
                             e.sw, e.ra, e.rb, e.busy, e.fault, e.rej, e.cnt);
                end
                total++;
                if (bus.reset_A && bus.reset_B) begin
                    bad++;
                    $display("FAIL reset_exclusive @%0t: got rA=1 rB=1, exp at most one high", $time);
                end
            end
        end
    end

    task automatic check_zero(input string name);
        logic [13:0] got;
        got = {bus.switch, bus.reset_A, bus.reset_B, bus.busy, bus.fault, bus.cmd_rej, bus.switch_cnt};
        total++;
        if (got !== 14'h0) begin
            bad++;
            $display("FAIL %s: got outputs=%h, exp 0000", name, got);
        end
    endtask

    initial begin
        bit ra, rb, seen;
        rst_n = 0;
        bus.io_a = 1; bus.io_b = 1; bus.com_swi = 0; bus.force_swi = 0;
        have_pending = 0;
        model_reset();
        #1;
        check_zero("reset_state");
        #21;
        rst_n = 1;

        // Directed cases from the test plan
        repeat (3) step(0, 0, 1, 1);
        step(0, 1, 1, 1);
        repeat (3) step(0, 0, 1, 1);
        step(0, 1, 1, 1);
        repeat (25) step(0, 0, 1, 1);
        repeat (5) step(0, 0, 0, 1);
        repeat (3) step(0, 0, 1, 1);
        repeat (20) step(0, 0, 0, 1);
        repeat (25) step(0, 0, 1, 1);
        repeat (20) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        repeat (25) step(0, 0, 1, 1);
        repeat (20) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        repeat (25) step(0, 0, 1, 1);
        step(0, 1, 1, 0);
        step(0, 1, 0, 1);
        step(1, 0, 1, 0);
        repeat (30) step(0, 0, 1, 1);
        step(1, 1, 1, 1);
        repeat (2) step(0, 0, 1, 1);
        step(0, 1, 1, 1);
        repeat (25) step(0, 0, 1, 1);

        // Random traffic: slowly flipping health lines, occasional requests
        ra = 1; rb = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) ra = !ra;
            if ($urandom_range(15) == 0) rb = !rb;
            step($urandom_range(49) == 0, $urandom_range(19) == 0, ra, rb);
        end
        repeat (30) step(0, 0, 1, 1);

        // Drive switch_cnt into saturation
        for (int i = 0; i < 260; i++) begin
            step(1, 0, 1, 1);
            step(0, 0, 1, 1);
        end
        repeat (25) step(0, 0, 1, 1);

        // Async reset in the middle of a reset_A pulse
        if (m_sel) begin
            step(1, 0, 1, 1);
            repeat (25) step(0, 0, 1, 1);
        end
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step(0, 0, 0, 1);
            @(negedge clk);
            #1;
            seen = bus.reset_A;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL reset_A_timeout: got reset_A=0 within 40 cycles, exp 1");
        end
        #1;
        rst_n = 0;
        #1;
        check_zero("async_reset");
        have_pending = 0;
        sb_q.delete();
        model_reset();
        bus.io_a = 1; bus.io_b = 1;
        #10;
        rst_n = 1;
        repeat (3) step(0, 0, 1, 1);
        step(0, 1, 1, 1);
        repeat (4) step(0, 0, 1, 1);
        flush();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
